// File: rtl/event_pkg.sv
// Shared definitions for the DVS event path: event word layout, frame length and TX FSM encodings.
// Used by the event filter and the transmit end.
package event_pkg;

  localparam int EV_FIELD_W = 2;
  localparam int EV_EVENT_W = 4 * EV_FIELD_W;
  localparam int EV_BEATS   = 4;
  localparam int BEAT_W     = 2;

  // Field offsets inside the packed word {x, y, p, t}, x in the MSBs.
  localparam int EV_X_OFS = 3 * EV_FIELD_W;
  localparam int EV_Y_OFS = 2 * EV_FIELD_W;
  localparam int EV_P_OFS = 1 * EV_FIELD_W;
  localparam int EV_T_OFS = 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic [EV_FIELD_W-1:0] x;
    logic [EV_FIELD_W-1:0] y;
    logic [EV_FIELD_W-1:0] p;
    logic [EV_FIELD_W-1:0] t;
  } event_t;

  function automatic logic [EV_EVENT_W-1:0] pack_event(input event_t ev);
    return {ev.x, ev.y, ev.p, ev.t};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock FIFO with first-word-fall-through read; caller must not push when full
// unless it pops in the same cycle, and must not pop when empty.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/event_tx.sv
// Event transmitter: queues {x,y,p,t} events and serializes each as a 4-beat frame
// (x first, tx_sof on x) over a valid/ready link, counting events lost to overflow.
module event_tx
  import event_pkg::*;
#(
  parameter int FIELD_W = EV_FIELD_W,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  input  logic [FIELD_W-1:0]         ev_x,
  input  logic [FIELD_W-1:0]         ev_y,
  input  logic [FIELD_W-1:0]         ev_p,
  input  logic [FIELD_W-1:0]         ev_t,
  input  logic                       tx_ready,
  output logic                       tx_valid,
  output logic [FIELD_W-1:0]         tx_data,
  output logic                       tx_sof,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int EVENT_W = 4 * FIELD_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [0:0]         state_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [EVENT_W-1:0] shift_q;
  logic [CNT_W-1:0]   drop_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [EVENT_W-1:0] fifo_dout;
  logic [EVENT_W-1:0] ev_word;

  logic send;
  logic hs;
  logic last_beat;

  assign ev_word   = {ev_x, ev_y, ev_p, ev_t};
  assign send      = (state_q == ST_SEND);
  assign hs        = send & tx_ready;
  assign last_beat = (beat_q == BEAT_W'(EV_BEATS - 1));

  // Pop when idle, or on the final beat handshake so the next frame follows with no bubble.
  assign fifo_pop  = ~fifo_empty & (~send | (hs & last_beat));
  assign fifo_push = ev_valid & (~fifo_full | fifo_pop);

  event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ev_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else if (fifo_pop) begin
      state_q <= ST_SEND;
      beat_q  <= '0;
    end else if (hs) begin
      if (last_beat) begin
        state_q <= ST_IDLE;
        beat_q  <= '0;
      end else begin
        beat_q  <= beat_q + 1'b1;
      end
    end
  end

  // Data path: no reset, the output is gated by the FSM state.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift_q <= fifo_dout;
    end else if (hs) begin
      shift_q <= shift_q << FIELD_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (ev_valid & fifo_full & ~fifo_pop) begin
      drop_q <= sat_inc(drop_q);
    end
  end

  assign tx_valid = send;
  assign tx_sof   = send & (beat_q == '0);
  assign tx_data  = send ? shift_q[EVENT_W-1 -: FIELD_W] : '0;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_event_tx.sv
// Self-checking bench for event_tx: directed scenarios plus random traffic against a queue-based model.
module tb_event_tx;

  localparam int FW = 2;
  localparam int DEPTH = 4;
  localparam int CW = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ev_valid;
  logic [FW-1:0] ev_x, ev_y, ev_p, ev_t;
  logic          tx_ready;
  logic          tx_valid;
  logic [FW-1:0] tx_data;
  logic          tx_sof;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of waiting words plus the frame currently on the link.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_beat;
  logic [7:0] m_word;
  int         m_drop;

  always #5 clk = ~clk;

  event_tx #(.FIELD_W(FW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_p       (ev_p),
    .ev_t       (ev_t),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_sof     (tx_sof),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  function automatic logic [14:0] exp_vec();
    logic [1:0] d;
    d = m_active ? 2'((m_word >> (2 * (3 - m_beat))) & 8'h3) : 2'd0;
    return {m_active, (m_active && m_beat == 0), d, 3'(mq.size()), 8'(m_drop)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {tx_valid, tx_sof, tx_data, fifo_level, drop_cnt};
  endfunction

  task automatic set_ev(input logic [7:0] w);
    ev_valid = 1'b1;
    {ev_x, ev_y, ev_p, ev_t} = w;
  endtask

  // Advance the model with the inputs present before the edge, then the DUT by one clock.
  task automatic tick();
    bit pop;
    bit full;
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_beat   = 0;
      m_drop   = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = 0;
      if (!m_active) pop = (mq.size() > 0);
      else if (tx_ready) begin
        if (m_beat < 3) m_beat++;
        else if (mq.size() > 0) pop = 1;
        else m_active = 0;
      end
      if (pop) begin
        m_word   = mq.pop_front();
        m_active = 1;
        m_beat   = 0;
      end
      if (ev_valid) begin
        if (!full || pop) mq.push_back({ev_x, ev_y, ev_p, ev_t});
        else if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ev_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev_valid = 1'b0; tx_ready = 1'b0;
    {ev_x, ev_y, ev_p, ev_t} = 8'h00;
    tick();
    tick();
    n_cmp++;
    if (dut_vec() !== 15'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 15'd0);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_model got=%h want=%h", dut_vec(), exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] got;
    logic [3:0] sofs;
    int nb, first;
    do_reset();
    tx_ready = 1'b1;
    set_ev(8'hD6);
    tick();
    ev_valid = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_latency1 got=%b want=0", tx_valid);
    end
    got = 0; sofs = 0; nb = 0; first = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL single_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      if (tx_valid && first < 0) first = i + 2;
      if (tx_valid && tx_ready && nb < 4) begin
        got = {got[5:0], tx_data}; sofs = {sofs[2:0], tx_sof}; nb++;
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_bad++; $display("FAIL single_first_valid got=%0d want=2", first);
    end
    n_cmp++;
    if ({nb[2:0], got, sofs} !== {3'd4, 8'hD6, 4'b1000}) begin
      n_bad++; $display("FAIL single_beats got=%0d/%h/%b want=4/d6/1000", nb, got, sofs);
    end
  endtask

  task automatic test_stall();
    logic [7:0] got;
    logic [3:0] prev;
    bit pvalid, pready;
    int nb;
    do_reset();
    tx_ready = 1'b1;
    set_ev(8'hD6);
    tick();
    ev_valid = 1'b0;
    got = 0; nb = 0; pvalid = 0; pready = 0; prev = 0;
    for (int k = 0; k < 16; k++) begin
      tx_ready = (k % 3 == 0);
      if (tx_valid && tx_ready) begin got = {got[5:0], tx_data}; nb++; end
      pvalid = tx_valid; pready = tx_ready; prev = {tx_valid, tx_sof, tx_data};
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stall_cycle%0d got=%h want=%h", k, dut_vec(), exp_vec());
      end
      if (pvalid && !pready) begin
        n_cmp++;
        if ({tx_valid, tx_sof, tx_data} !== prev) begin
          n_bad++; $display("FAIL stall_hold%0d got=%h want=%h", k, {tx_valid, tx_sof, tx_data}, prev);
        end
      end
    end
    n_cmp++;
    if ({nb[3:0], got} !== {4'd4, 8'hD6}) begin
      n_bad++; $display("FAIL stall_beats got=%0d/%h want=4/d6", nb, got);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] evs[8];
    logic [7:0] cur;
    logic [39:0] got, want;
    int nb, bubbles;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      evs[i] = 8'($urandom);
      set_ev(evs[i]);
      tick();
    end
    ev_valid = 1'b0;
    tick();
    n_cmp++;
    if ({fifo_level, drop_cnt} !== {3'd4, 8'd3}) begin
      n_bad++; $display("FAIL overflow_counts got=%0d/%0d want=4/3", fifo_level, drop_cnt);
    end
    tx_ready = 1'b1;
    got = 0; nb = 0; bubbles = 0; cur = 0;
    for (int i = 0; i < 24; i++) begin
      if (nb < 20 && !tx_valid) bubbles++;
      if (tx_valid) begin cur = {cur[5:0], tx_data}; nb++; if (nb % 4 == 0) got = {got[31:0], cur}; end
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL overflow_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    want = {evs[0], evs[1], evs[2], evs[3], evs[4]};
    n_cmp++;
    if ({nb[5:0], bubbles[3:0], got} !== {6'd20, 4'd0, want}) begin
      n_bad++; $display("FAIL overflow_order got=%0d/%0d/%h want=20/0/%h", nb, bubbles, got, want);
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0] last;
    bit found;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin set_ev(8'($urandom)); tick(); end
    ev_valid = 1'b0;
    tick();
    tx_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_active && m_beat == 3) found = 1;
      else tick();
    end
    n_cmp++;
    if (!found || fifo_level !== 3'd4) begin
      n_bad++; $display("FAIL pushpop_setup got=%0d/%0d want=1/4", found, fifo_level);
    end
    last = 8'($urandom);
    set_ev(last);
    tick();
    ev_valid = 1'b0;
    n_cmp++;
    if ({fifo_level, drop_cnt, tx_sof} !== {3'd4, 8'd0, 1'b1}) begin
      n_bad++; $display("FAIL pushpop_accept got=%0d/%0d/%b want=4/0/1", fifo_level, drop_cnt, tx_sof);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL pushpop_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic [3:0] sofs;
    do_reset();
    tx_ready = 1'b1;
    set_ev(8'h9C);
    tick();
    ev_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({tx_valid, tx_sof, tx_data} !== {1'b1, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL midreset_beat2 got=%b%b/%0d want=10/1", tx_valid, tx_sof, tx_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({tx_valid, tx_data, fifo_level} !== {1'b0, 2'd0, 3'd0}) begin
      n_bad++; $display("FAIL midreset_clear got=%b/%0d/%0d want=0/0/0", tx_valid, tx_data, fifo_level);
    end
    set_ev(8'h4B);
    tick();
    ev_valid = 1'b0;
    got = 0; sofs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL midreset_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      if (i < 4) begin got = {got[5:0], tx_data}; sofs = {sofs[2:0], tx_sof}; end
    end
    n_cmp++;
    if ({got, sofs} !== {8'h4B, 4'b1000}) begin
      n_bad++; $display("FAIL midreset_frame got=%h/%b want=4b/1000", got, sofs);
    end
  endtask

  task automatic test_drop_sat();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 265; i++) begin
      set_ev(8'($urandom));
      tick();
      if (i % 16 == 0) begin
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL dropsat_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (drop_cnt !== 8'hFF) begin
      n_bad++; $display("FAIL dropsat_max got=%0d want=255", drop_cnt);
    end
    for (int i = 0; i < 4; i++) tick();
    ev_valid = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'hFF) begin
      n_bad++; $display("FAIL dropsat_hold got=%0d want=255", drop_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) set_ev(8'($urandom));
      else ev_valid = 1'b0;
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    ev_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_push_on_pop();
    test_reset_mid();
    test_drop_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
